// File: rtl/sccpu_pkg.sv
// Shared definitions for the sccpu datapath: ALU opcodes used by both the ALU
// and the control unit.
package sccpu_pkg;

  localparam int unsigned DataWidth = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  // Low two opcode bits pick the functional group; bit 2 picks within it.
  typedef enum logic [1:0] {
    GrpAddSub = 2'b00,
    GrpAndOr  = 2'b01,
    GrpXorLui = 2'b10,
    GrpShift  = 2'b11
  } alu_grp_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter: left, logical right or arithmetic right.
module alu_shifter
  import sccpu_pkg::*;
(
  input  logic [DataWidth-1:0] d,
  input  logic [4:0]           sa,
  input  logic                 right,
  input  logic                 arith,
  output logic [DataWidth-1:0] y
);

  logic [DataWidth-1:0] stage [6];
  logic                 fill;

  // Right shifts are done as five log-stages; fill bit is the sign only for SRA.
  always_comb begin
    fill     = arith & d[DataWidth-1];
    stage[0] = d;
    for (int i = 0; i < 5; i++) begin
      if (!sa[i]) begin
        stage[i+1] = stage[i];
      end else if (right) begin
        stage[i+1] = (stage[i] >> (1 << i)) |
                     ({DataWidth{fill}} & ~({DataWidth{1'b1}} >> (1 << i)));
      end else begin
        stage[i+1] = stage[i] << (1 << i);
      end
    end
    y = stage[5];
  end

endmodule

// File: rtl/sccpu_alu.sv
// Registered 32-bit ALU for the sccpu datapath; one cycle of latency.
module sccpu_alu
  import sccpu_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  input  logic [3:0]           aluc,
  output logic [DataWidth-1:0] r,
  output logic                 z
);

  logic                 sub;
  logic [DataWidth-1:0] addsub;
  logic [DataWidth-1:0] shifted;
  logic                 shr;
  logic [DataWidth-1:0] r_d;
  logic                 z_d;
  logic [DataWidth-1:0] r_q;
  logic                 z_q;
  alu_grp_e             grp;

  assign grp = alu_grp_e'(aluc[1:0]);
  assign sub = aluc[2];
  // One adder serves ADD and SUB: invert b and carry in one for subtraction.
  assign addsub = a + (b ^ {DataWidth{sub}}) + {{(DataWidth-1){1'b0}}, sub};
  // 1011 is unused and falls back to SLL, so a right shift needs bit 2 set.
  assign shr = aluc[2];

  alu_shifter u_shifter (
    .d     (b),
    .sa    (a[4:0]),
    .right (shr),
    .arith (aluc[3] & aluc[2]),
    .y     (shifted)
  );

  // Select the result for this cycle's opcode and derive the zero flag from it.
  always_comb begin
    r_d = '0;
    unique case (grp)
      GrpAddSub: r_d = addsub;
      GrpAndOr:  r_d = aluc[2] ? (a | b) : (a & b);
      GrpXorLui: r_d = aluc[2] ? {b[15:0], 16'h0000} : (a ^ b);
      GrpShift:  r_d = shifted;
      default:   r_d = '0;
    endcase
    z_d = (r_d == '0);
  end

  // Output register; reset value keeps z consistent with r == 0.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_q <= '0;
      z_q <= 1'b1;
    end else begin
      r_q <= r_d;
      z_q <= z_d;
    end
  end

  assign r = r_q;
  assign z = z_q;

endmodule

// File: tb/tb_sccpu_alu.sv
// Self-checking bench for sccpu_alu: directed vector table, random stream
// against a reference model, and reset corner cases.
module tb_sccpu_alu;

  logic        clock;
  logic        resetn;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic [31:0] r;
  logic        z;

  int n_total;
  int n_pass;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic [31:0] exp_r;
    logic        exp_z;
  } vec_t;

  vec_t vecs[$];

  sccpu_alu dut (
    .clock  (clock),
    .resetn (resetn),
    .a      (a),
    .b      (b),
    .aluc   (aluc),
    .r      (r),
    .z      (z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference ALU computed directly from the opcode table.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [3:0] op);
    logic signed [31:0] sy;
    int unsigned        sh;
    sy = y;
    sh = int'(x % 32);
    casez (op)
      4'b?000: return x + y;
      4'b?100: return x - y;
      4'b?001: return x & y;
      4'b?101: return x | y;
      4'b?010: return x ^ y;
      4'b?110: return y * 32'h0001_0000;
      4'b1111: return sy >>> sh;
      4'b0111: return y >> sh;
      default: return y << sh;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] exp_r, input logic exp_z);
    n_total++;
    if (r === exp_r && z === exp_z) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got r=%08h z=%0b, expected r=%08h z=%0b", name, r, z, exp_r, exp_z);
    end
  endtask

  // Apply inputs, cross one rising edge, settle just after it.
  task automatic step(input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vop);
    a    = va;
    b    = vb;
    aluc = vop;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] exp_q;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;

    n_total = 0;
    n_pass  = 0;

    vecs.push_back('{"add", 32'd12, 32'd8, 4'b1000, 32'd20, 1'b0});
    vecs.push_back('{"add_wrap", 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, 1'b1});
    vecs.push_back('{"sub_zero", 32'd8, 32'd8, 4'b0100, 32'd0, 1'b1});
    vecs.push_back('{"sub_neg", 32'd3, 32'd5, 4'b0100, 32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{"and", 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0001, 32'h00F0_000F, 1'b0});
    vecs.push_back('{"or", 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0101, 32'hFFF0_0FFF, 1'b0});
    vecs.push_back('{"xor", 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0010, 32'hFF00_0FF0, 1'b0});
    vecs.push_back('{"lui", 32'hF0F0_00FF, 32'h1234_ABCD, 4'b0110, 32'hABCD_0000, 1'b0});
    vecs.push_back('{"lui_hi", 32'h0, 32'hFFFF_0000, 4'b1110, 32'h0, 1'b1});
    vecs.push_back('{"sll", 32'h0000_0024, 32'h8000_0001, 4'b0011, 32'h0000_0010, 1'b0});
    vecs.push_back('{"srl", 32'h0000_0024, 32'h8000_0001, 4'b0111, 32'h0800_0000, 1'b0});
    vecs.push_back('{"sra", 32'h0000_0024, 32'h8000_0001, 4'b1111, 32'hF800_0000, 1'b0});
    vecs.push_back('{"sra_sa0", 32'h0000_0020, 32'h8000_0001, 4'b1111, 32'h8000_0001, 1'b0});
    vecs.push_back('{"sll_sa0", 32'hFFFF_FFE0, 32'h1234_5678, 4'b0011, 32'h1234_5678, 1'b0});
    vecs.push_back('{"unused_sll", 32'h0000_0024, 32'h8000_0001, 4'b1011, 32'h0000_0010, 1'b0});
    vecs.push_back('{"sra_pos", 32'd31, 32'h7FFF_FFFF, 4'b1111, 32'h0, 1'b1});
    vecs.push_back('{"srl_31", 32'd31, 32'h8000_0000, 4'b0111, 32'h1, 1'b0});

    // Reset for two cycles with undefined operands.
    resetn = 1'b0;
    step('x, 'x, 'x);
    step('x, 'x, 'x);
    check("reset", 32'h0, 1'b1);
    resetn = 1'b1;

    // Directed table, one op per edge.
    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, vecs[i].aluc);
      check(vecs[i].name, vecs[i].exp_r, vecs[i].exp_z);
    end

    // Back-to-back random stream: each edge must show the model result of the
    // inputs applied just before it.
    for (int i = 0; i < 300; i++) begin
      ra  = $urandom();
      rb  = $urandom();
      rop = 4'($urandom_range(0, 15));
      if (i % 7 == 0) rb = ra;
      if (i % 5 == 0) ra = ra & 32'h3F;
      exp_q = model(ra, rb, rop);
      step(ra, rb, rop);
      check("random", exp_q, exp_q == 32'h0);
    end

    // Mid-stream reset discards the operation sampled at that edge.
    step(32'd3, 32'd4, 4'b0000);
    check("pre_reset", 32'd7, 1'b0);
    resetn = 1'b0;
    step(32'd12, 32'd8, 4'b0000);
    check("mid_reset", 32'h0, 1'b1);
    resetn = 1'b1;
    step(32'd12, 32'd8, 4'b0000);
    check("post_reset", 32'd20, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sccpu_alu.md
# sccpu_alu

Registered 32-bit integer ALU for the single-cycle CPU datapath (sccpu). It takes two 32-bit operands and a 4-bit operation code and produces a 32-bit result plus a zero flag. The zero flag drives branch-equal/not-equal decisions. Inputs are sampled on each rising clock edge, and the outputs are registered, giving one cycle of latency.

## Interface
- No parameters; the data width is fixed at 32 bits.
- clock  input  1  system clock; all state updates on its rising edge
- resetn  input  1  synchronous, active-low reset
- a  input  32  operand A; also the shift amount source (a[4:0]) for shift operations
- b  input  32  operand B; the data operand for shifts and LUI
- aluc  input  4  operation select, encoding below
- r  output  32  registered result
- z  output  1  registered zero flag; 1 when r == 0

## Operation
- Opcode decode, where x means don't-care:
  - x000 ADD: r = a + b, wrap modulo 2^32, no overflow trap.
  - x100 SUB: r = a - b, wrap modulo 2^32.
  - x001 AND: r = a & b.
  - x101 OR: r = a | b.
  - x010 XOR: r = a ^ b.
  - x110 LUI: r = {b[15:0], 16'h0000}; a is ignored.
  - 0011 SLL: r = b << a[4:0].
  - 0111 SRL: r = b >> a[4:0], zero fill.
  - 1111 SRA: r = b >>> a[4:0], sign fill from b[31].
  - 1011 (unused): treat as SLL.
- Shift rules:
  - Only a[4:0] is used; a[31:5] is ignored.
  - A shift of 0 returns b unchanged.
- z is computed from the same cycle's next result: z_next = (r_next == 32'h0).
- Arithmetic is sign-agnostic; no carry, overflow or negative flags are produced.

## Timing
- Latency is 1 cycle: operands and aluc present before rising edge N appear on r/z after edge N.
- The block is fully pipelined and accepts a new operation every cycle. There is no handshake and no stall.
- Reset:
  - When resetn == 0 at a rising edge: r <= 32'h0 and z <= 1. These are consistent with each other.
  - Reset overrides any operation in flight; the operands sampled at that edge are discarded.
  - The first valid result appears at the edge after resetn returns to 1.
- Inputs that are X/undefined while resetn == 0 must not propagate to the outputs.
- No combinational path from the inputs to r/z.

## Structure
- Shared package `sccpu_pkg`:
  - ALU opcode localparams: ALU_ADD=4'b0000, ALU_SUB=4'b0100, ALU_AND=4'b0001, ALU_OR=4'b0101, ALU_XOR=4'b0010, ALU_LUI=4'b0110, ALU_SLL=4'b0011, ALU_SRL=4'b0111, ALU_SRA=4'b1111.
  - The control unit imports the same constants.
- Natural sub-module: `alu_shifter`, a combinational barrel shifter with inputs d[31:0], sa[4:0], right, arith.
- The add/sub path shares one adder (b inverted plus carry-in for SUB).
- The output register stage sits in the top module.

## Test plan
- ADD: reset for 2 cycles, then a=12, b=8, aluc=4'b1000 -> after the next edge r=20, z=0. Also a=32'hFFFF_FFFF, b=1, ADD -> r=0, z=1.
- SUB:
  - a=8, b=8, aluc=4'b0100 -> r=0, z=1.
  - a=3, b=5 -> r=32'hFFFF_FFFE, z=0.
- Logic and LUI, with a=32'hF0F0_00FF, b=32'h0FF0_0F0F:
  - AND -> 32'h00F0_000F.
  - OR -> 32'hFFF0_0FFF.
  - XOR -> 32'hFF00_0FF0.
  - LUI with b=32'h1234_ABCD -> 32'hABCD_0000.
- Shifts, with b=32'h8000_0001 and a=32'h0000_0024 (so a[4:0]=4):
  - SLL -> 32'h0000_0010.
  - SRL -> 32'h0800_0000.
  - SRA -> 32'hF800_0000.
  - a[4:0]=0 -> b unchanged.
- Back-to-back and latency: change the operation every cycle for 10 cycles against a reference model. Each result must appear exactly one edge after its inputs, with no bubbles.
- Mid-stream reset: hold resetn=0 for one edge while a=12, b=8, ADD -> r=0, z=1 after that edge. Release reset -> r=20 after the following edge.
